acumulador_moedas: RTL and testbench

ACUMULADOR_MOEDAS -- requirements
Module: acumulador_moedas

---
 rtl/acumulador_moedas.sv | 173 +++++++++++++++++
 tb/tb_acumulador_moedas.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/acumulador_moedas.sv
// Coin accumulator for a vending controller: sums 1/2-unit coins, hands the
// total and product code to an external comparator, then dispenses or refunds.
module acumulador_moedas #(
  parameter int VALOR_MAX = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       moeda_valida,
  input  logic [1:0] moeda,
  input  logic [2:0] produto,
  input  logic       confirmar,
  input  logic       cancelar,
  input  logic       liberarProduto,
  input  logic       devolverMoedas,
  output logic [3:0] valorMoedas,
  output logic [2:0] valorProduto,
  output logic       enable,
  output logic       dispensar,
  output logic       devolver,
  output logic [3:0] valorDevolvido,
  output logic       rejeitarMoeda,
  output logic       ocupado
);

  localparam logic [2:0] OCIOSO     = 3'd0;
  localparam logic [2:0] ACUMULANDO = 3'd1;
  localparam logic [2:0] COMPARANDO = 3'd2;
  localparam logic [2:0] ENTREGA    = 3'd3;
  localparam logic [2:0] DEVOLUCAO  = 3'd4;

  localparam logic [4:0] LIMITE = 5'(VALOR_MAX);

  // Coin code to unit value; zero marks an invalid code.
  function automatic logic [1:0] coin_value(input logic [1:0] code);
    case (code)
      2'b01:   coin_value = 2'd1;
      2'b10:   coin_value = 2'd2;
      default: coin_value = 2'd0;
    endcase
  endfunction

  function automatic logic is_busy(input logic [2:0] st);
    case (st)
      COMPARANDO, ENTREGA, DEVOLUCAO: is_busy = 1'b1;
      default:                        is_busy = 1'b0;
    endcase
  endfunction

  logic [2:0] state_r, state_s;
  logic [3:0] total_r, total_s;
  logic [2:0] prod_r, prod_s;
  logic       enable_r, enable_s;
  logic       dispensar_r, dispensar_s;
  logic       devolver_r, devolver_s;
  logic [3:0] devolvido_r, devolvido_s;
  logic       rejeitar_r, rejeitar_s;
  logic       ocupado_r, ocupado_s;
  logic [1:0] coin_val_s;
  logic [4:0] coin_sum_s;
  logic       accepting_s;
  logic       coin_ok_s;

  // Coin acceptance: only while accepting, never alongside a purchase/abort request.
  always_comb begin
    coin_val_s  = coin_value(moeda);
    coin_sum_s  = {1'b0, total_r} + {3'b000, coin_val_s};
    accepting_s = (state_r == OCIOSO) || (state_r == ACUMULANDO);
    if (moeda_valida && (coin_val_s != 2'd0) && accepting_s && !confirmar && !cancelar &&
        (coin_sum_s <= LIMITE)) begin
      coin_ok_s = 1'b1;
    end else begin
      coin_ok_s = 1'b0;
    end
  end

  // Next-state and next-output computation; every output is registered below.
  always_comb begin
    state_s     = state_r;
    total_s     = total_r;
    prod_s      = prod_r;
    enable_s    = 1'b0;
    dispensar_s = 1'b0;
    devolver_s  = 1'b0;
    devolvido_s = 4'd0;
    rejeitar_s  = moeda_valida && !coin_ok_s;

    case (state_r)
      OCIOSO: begin
        if (coin_ok_s) begin
          total_s = coin_sum_s[3:0];
          state_s = ACUMULANDO;
        end else begin
          state_s = OCIOSO;
        end
      end
      ACUMULANDO: begin
        if (cancelar) begin
          state_s     = DEVOLUCAO;
          devolver_s  = 1'b1;
          devolvido_s = total_r;
        end else if (confirmar && (total_r != 4'd0)) begin
          state_s  = COMPARANDO;
          prod_s   = produto;
          enable_s = 1'b1;
        end else if (coin_ok_s) begin
          total_s = coin_sum_s[3:0];
        end else begin
          state_s = ACUMULANDO;
        end
      end
      COMPARANDO: begin
        // Anything other than a clean match refunds.
        if (liberarProduto && !devolverMoedas) begin
          state_s     = ENTREGA;
          dispensar_s = 1'b1;
        end else begin
          state_s     = DEVOLUCAO;
          devolver_s  = 1'b1;
          devolvido_s = total_r;
        end
      end
      ENTREGA: begin
        state_s = OCIOSO;
        total_s = 4'd0;
      end
      DEVOLUCAO: begin
        state_s = OCIOSO;
        total_s = 4'd0;
      end
      default: begin
        state_s = OCIOSO;
        total_s = 4'd0;
      end
    endcase

    ocupado_s = is_busy(state_s);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= OCIOSO;
      total_r     <= 4'd0;
      prod_r      <= 3'd0;
      enable_r    <= 1'b0;
      dispensar_r <= 1'b0;
      devolver_r  <= 1'b0;
      devolvido_r <= 4'd0;
      rejeitar_r  <= 1'b0;
      ocupado_r   <= 1'b0;
    end else begin
      state_r     <= state_s;
      total_r     <= total_s;
      prod_r      <= prod_s;
      enable_r    <= enable_s;
      dispensar_r <= dispensar_s;
      devolver_r  <= devolver_s;
      devolvido_r <= devolvido_s;
      rejeitar_r  <= rejeitar_s;
      ocupado_r   <= ocupado_s;
    end
  end

  assign valorMoedas    = total_r;
  assign valorProduto   = prod_r;
  assign enable         = enable_r;
  assign dispensar      = dispensar_r;
  assign devolver       = devolver_r;
  assign valorDevolvido = devolvido_r;
  assign rejeitarMoeda  = rejeitar_r;
  assign ocupado        = ocupado_r;

endmodule

// File: tb/tb_acumulador_moedas.sv
// Bench for acumulador_moedas: directed vector table, reset corner case and
// randomized traffic against a transaction-level reference model.
module tb_acumulador_moedas;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       moeda_valida = 1'b0;
  logic [1:0] moeda = 2'b00;
  logic [2:0] produto = 3'd0;
  logic       confirmar = 1'b0;
  logic       cancelar = 1'b0;
  logic       liberarProduto = 1'b0;
  logic       devolverMoedas = 1'b0;
  logic [3:0] valorMoedas;
  logic [2:0] valorProduto;
  logic       enable;
  logic       dispensar;
  logic       devolver;
  logic [3:0] valorDevolvido;
  logic       rejeitarMoeda;
  logic       ocupado;

  int checks = 0;
  int failures = 0;

  acumulador_moedas #(.VALOR_MAX(15)) dut (
    .clk(clk), .rst(rst), .moeda_valida(moeda_valida), .moeda(moeda),
    .produto(produto), .confirmar(confirmar), .cancelar(cancelar),
    .liberarProduto(liberarProduto), .devolverMoedas(devolverMoedas),
    .valorMoedas(valorMoedas), .valorProduto(valorProduto), .enable(enable),
    .dispensar(dispensar), .devolver(devolver), .valorDevolvido(valorDevolvido),
    .rejeitarMoeda(rejeitarMoeda), .ocupado(ocupado)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic rst, mv; logic [1:0] moeda; logic [2:0] prod;
    logic conf, canc, lib, dvm; logic [15:0] exp;
  } vec_t;
  vec_t vecs[$];

  // Output bundle layout: val(4) prod(3) en disp dev devv(4) rej ocu
  function automatic logic [15:0] pk(int val, int prod, int en, int disp, int dev,
                                     int devv, int rej, int ocu);
    pk = {4'(val), 3'(prod), 1'(en), 1'(disp), 1'(dev), 4'(devv), 1'(rej), 1'(ocu)};
  endfunction

  function automatic logic [15:0] outs();
    outs = {valorMoedas, valorProduto, enable, dispensar, devolver, valorDevolvido,
            rejeitarMoeda, ocupado};
  endfunction

  task automatic check(string name, logic [15:0] act, logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (val,prod,en,disp,dev,devv,rej,ocu)", name, act, exp);
    end
  endtask

  task automatic add(logic r, logic mv, logic [1:0] m, logic [2:0] p, logic cf, logic cn,
                     logic lb, logic dv, logic [15:0] e);
    vec_t v;
    v.rst = r; v.mv = mv; v.moeda = m; v.prod = p; v.conf = cf; v.canc = cn;
    v.lib = lb; v.dvm = dv; v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic drive(logic r, logic mv, logic [1:0] m, logic [2:0] p, logic cf, logic cn,
                       logic lb, logic dv);
    rst = r; moeda_valida = mv; moeda = m; produto = p; confirmar = cf; cancelar = cn;
    liberarProduto = lb; devolverMoedas = dv;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: the machine accepts coins while idle, total==0 meaning OCIOSO.
  int m_total, m_phase, m_prod;
  logic [15:0] m_exp;

  task automatic model_step(logic r, logic mv, logic [1:0] m, logic [2:0] p, logic cf,
                            logic cn, logic lb, logic dv);
    int cv, en, disp, dev, devv, rej;
    bit took;
    cv = (m == 2'b01) ? 1 : (m == 2'b10) ? 2 : 0;
    en = 0; disp = 0; dev = 0; devv = 0; rej = 0; took = 0;
    if (r) begin
      m_total = 0; m_phase = 0; m_prod = 0;
    end else if (m_phase == 0) begin
      if (cn && m_total > 0) begin
        m_phase = 2; dev = 1; devv = m_total;
      end else if (cf && m_total > 0) begin
        m_phase = 1; m_prod = p; en = 1;
      end else if (mv && cv > 0 && !cf && !cn && m_total + cv <= 15) begin
        m_total += cv; took = 1;
      end
      rej = (mv && !took) ? 1 : 0;
    end else if (m_phase == 1) begin
      rej = mv;
      m_phase = 2;
      if (lb && !dv) disp = 1;
      else begin dev = 1; devv = m_total; end
    end else begin
      rej = mv; m_phase = 0; m_total = 0;
    end
    m_exp = r ? 16'h0 : pk(m_total, m_prod, en, disp, dev, devv, rej, m_phase != 0);
  endtask

  initial begin
    // Directed table: each row is one cycle, expectation sampled after its edge.
    add(1,0,2'b00,3'd0,0,0,0,0, pk(0,0,0,0,0,0,0,0));
    add(0,1,2'b10,3'd0,0,0,0,0, pk(2,0,0,0,0,0,0,0));
    add(0,1,2'b10,3'd0,0,0,0,0, pk(4,0,0,0,0,0,0,0));
    add(0,0,2'b00,3'd2,1,0,0,0, pk(4,2,1,0,0,0,0,1));
    add(0,0,2'b00,3'd0,0,0,1,0, pk(4,2,0,1,0,0,0,1));
    add(0,0,2'b00,3'd0,0,0,0,0, pk(0,2,0,0,0,0,0,0));
    add(0,1,2'b01,3'd0,0,0,0,0, pk(1,2,0,0,0,0,0,0));
    add(0,1,2'b10,3'd0,0,0,0,0, pk(3,2,0,0,0,0,0,0));
    add(0,0,2'b00,3'd1,1,0,0,0, pk(3,1,1,0,0,0,0,1));
    add(0,0,2'b00,3'd0,0,0,0,1, pk(3,1,0,0,1,3,0,1));
    add(0,0,2'b00,3'd0,0,0,0,0, pk(0,1,0,0,0,0,0,0));
    add(0,1,2'b10,3'd0,0,0,0,0, pk(2,1,0,0,0,0,0,0));
    add(0,0,2'b00,3'd5,1,0,0,0, pk(2,5,1,0,0,0,0,1));
    add(0,0,2'b00,3'd0,0,0,1,1, pk(2,5,0,0,1,2,0,1));
    add(0,0,2'b00,3'd0,0,0,0,0, pk(0,5,0,0,0,0,0,0));
    add(0,1,2'b11,3'd0,0,0,0,0, pk(0,5,0,0,0,0,1,0));
    add(0,1,2'b00,3'd0,0,0,0,0, pk(0,5,0,0,0,0,1,0));
    add(0,1,2'b01,3'd0,0,0,0,0, pk(1,5,0,0,0,0,0,0));
    add(0,0,2'b00,3'd3,1,0,0,0, pk(1,3,1,0,0,0,0,1));
    add(0,1,2'b01,3'd0,0,0,0,0, pk(1,3,0,0,1,1,1,1));
    add(0,1,2'b10,3'd0,0,0,0,0, pk(0,3,0,0,0,0,1,0));
    add(0,1,2'b01,3'd0,1,0,0,0, pk(0,3,0,0,0,0,1,0));
    add(0,0,2'b00,3'd0,0,1,0,0, pk(0,3,0,0,0,0,0,0));
    add(0,1,2'b10,3'd0,0,0,0,0, pk(2,3,0,0,0,0,0,0));
    add(0,1,2'b10,3'd0,0,0,0,0, pk(4,3,0,0,0,0,0,0));
    add(0,1,2'b01,3'd0,0,0,0,0, pk(5,3,0,0,0,0,0,0));
    add(0,0,2'b00,3'd7,1,1,0,0, pk(5,3,0,0,1,5,0,1));
    add(0,0,2'b00,3'd0,0,0,0,0, pk(0,3,0,0,0,0,0,0));
    for (int i = 1; i <= 7; i++) add(0,1,2'b10,3'd0,0,0,0,0, pk(2*i,3,0,0,0,0,0,0));
    add(0,1,2'b10,3'd0,0,0,0,0, pk(14,3,0,0,0,0,1,0));
    add(0,1,2'b01,3'd0,0,0,0,0, pk(15,3,0,0,0,0,0,0));
    add(0,1,2'b01,3'd0,0,0,0,0, pk(15,3,0,0,0,0,1,0));
    add(0,0,2'b00,3'd0,0,1,0,0, pk(15,3,0,0,1,15,0,1));
    add(0,0,2'b00,3'd0,0,0,0,0, pk(0,3,0,0,0,0,0,0));

    #1;
    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].mv, vecs[i].moeda, vecs[i].prod, vecs[i].conf,
            vecs[i].canc, vecs[i].lib, vecs[i].dvm);
      tick();
      check($sformatf("vec%0d", i), outs(), vecs[i].exp);
    end

    // Asynchronous reset while COMPARANDO with total 6 and a pending match.
    for (int i = 0; i < 3; i++) begin
      drive(0,1,2'b10,3'd0,0,0,0,0);
      tick();
    end
    drive(0,0,2'b00,3'd4,1,0,1,0);
    tick();
    check("rst_pre_compare", outs(), pk(6,4,1,0,0,0,0,1));
    #2 rst = 1'b1;
    #1 check("rst_immediate", outs(), 16'h0000);
    drive(1,0,2'b00,3'd0,0,0,1,0);
    tick();
    check("rst_held", outs(), 16'h0000);
    #4 rst = 1'b0;
    liberarProduto = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("rst_no_pulse%0d", i), outs(), 16'h0000);
    end
    drive(0,1,2'b01,3'd0,0,0,0,0);
    tick();
    check("rst_first_coin", outs(), pk(1,0,0,0,0,0,0,0));

    // Randomized traffic against the model, starting from a clean reset.
    drive(1,0,2'b00,3'd0,0,0,0,0);
    model_step(1,0,2'b00,3'd0,0,0,0,0);
    tick();
    check("rand_reset", outs(), m_exp);
    for (int n = 0; n < 3000; n++) begin
      logic r, mv, cf, cn, lb, dv;
      logic [1:0] m;
      logic [2:0] p;
      r  = ($urandom_range(0, 255) == 0);
      mv = $urandom_range(0, 1);
      m  = 2'($urandom_range(0, 3));
      p  = 3'($urandom_range(0, 7));
      cf = ($urandom_range(0, 7) == 0);
      cn = ($urandom_range(0, 15) == 0);
      lb = $urandom_range(0, 1);
      dv = ($urandom_range(0, 3) == 0);
      drive(r, mv, m, p, cf, cn, lb, dv);
      model_step(r, mv, m, p, cf, cn, lb, dv);
      tick();
      check($sformatf("rand%0d", n), outs(), m_exp);
      if (dispensar && devolver) begin
        checks++; failures++;
        $display("FAIL rand_exclusive%0d: dispensar=1 devolver=1 required not both", n);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
